reg_wb_arb: RTL

Write-back arbiter that drives the register file's single write port (reg_wr, rd, rd_d) from two producers: the single-cycle ALU and the in-order data-memory load path. It tracks outstanding load destinations in a small tag FIFO, merges ALU and load results onto the one write port, and raises a stall to decode on any RAW or WAW hazard with a not-yet-written register. It sits between execute/memory and the register file.

---
 rtl/reg_wb_arb_pkg.sv | 22 ++
 rtl/wb_tag_fifo.sv | 73 +++++++
 rtl/reg_wb_arb.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/reg_wb_arb_pkg.sv
// Shared constants and types for the write-back arbiter.
// Holds the register-file geometry (REG_LEN data bits, REG_NUM registers),
// the default number of outstanding loads (WB_LD_DEPTH), and the type that
// names which producer owns the write port in a given cycle.
package reg_wb_arb_pkg;

   localparam int REG_LEN     = 32;
   localparam int REG_NUM     = 32;
   localparam int WB_ADDR_LEN = $clog2(REG_NUM);
   localparam int WB_LD_DEPTH = 2;

   // Number of decode operands checked for hazards: rs1, rs2 and rd.
   localparam int WB_NUM_CHK  = 3;

   typedef enum logic [1:0] {
      SRC_NONE,
      SRC_LOAD,
      SRC_SKID,
      SRC_ALU
   } wb_src_e;

endpackage

// File: rtl/wb_tag_fifo.sv
// Tag FIFO that remembers the destination register of every load still in
// flight to data memory. Loads return in order, so the head entry always
// belongs to the next response.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   push, push_rd   append a destination tag
//   pop             drop the head tag (only while not empty)
//   head_rd         destination of the oldest outstanding load
//   full, empty     occupancy flags
//   chk, hit        per-operand "matches some valid entry" flags
module wb_tag_fifo #(
   parameter int ADDR_LEN = 5,
   parameter int LD_DEPTH = 2,
   parameter int NUM_CHK  = 3
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              push,
   input  logic [ADDR_LEN-1:0]               push_rd,
   input  logic                              pop,
   output logic [ADDR_LEN-1:0]               head_rd,
   output logic                              full,
   output logic                              empty,
   input  logic [NUM_CHK-1:0][ADDR_LEN-1:0]  chk,
   output logic [NUM_CHK-1:0]                hit
);

   localparam int PTR_W = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;

   logic [ADDR_LEN-1:0] entry [LD_DEPTH];
   logic [LD_DEPTH-1:0] valid;
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;

   assign head_rd = entry[rd_ptr];
   assign full    = &valid;
   assign empty   = ~|valid;

   // Circular buffer with one valid bit per slot. A push and a pop in the
   // same cycle while full both target the same slot; the push is written
   // last so the slot stays valid and holds the new tag.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (pop) begin
            valid[rd_ptr] <= 1'b0;
            rd_ptr        <= rd_ptr + 1'b1;
         end
         if (push) begin
            entry[wr_ptr] <= push_rd;
            valid[wr_ptr] <= 1'b1;
            wr_ptr        <= wr_ptr + 1'b1;
         end
      end
   end

   // Compare every decode operand against every live slot in parallel so
   // the hazard check does not depend on FIFO order.
   always_comb begin
      hit = '0;
      for (int i = 0; i < NUM_CHK; i++) begin
         for (int j = 0; j < LD_DEPTH; j++) begin
            if (valid[j] && (entry[j] == chk[i])) begin
               hit[i] = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/reg_wb_arb.sv
// Write-back arbiter for the register file's single write port.
// Merges single-cycle ALU results and in-order load responses, keeps the
// destinations of outstanding loads in a tag FIFO, parks an ALU result that
// collides with a load response in a one-entry skid register, and raises a
// decode stall on any RAW/WAW hazard with a register not yet written.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   alu_valid/alu_rd/alu_d/alu_ready ALU result handshake
//   ld_issue/ld_issue_rd/ld_issue_ready  load issue (tag push)
//   ld_resp_valid/ld_resp_d          load data return (tag pop)
//   chk_rs1/chk_rs2/chk_rd, stall    decode hazard query
//   reg_wr/rd/rd_d                   registered register-file write port
//   err                              sticky: response with no load pending
module reg_wb_arb
   import reg_wb_arb_pkg::*;
#(
   parameter int ADDR_LEN = WB_ADDR_LEN,
   parameter int LD_DEPTH = WB_LD_DEPTH
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                alu_valid,
   input  logic [ADDR_LEN-1:0] alu_rd,
   input  logic [REG_LEN-1:0]  alu_d,
   output logic                alu_ready,
   input  logic                ld_issue,
   input  logic [ADDR_LEN-1:0] ld_issue_rd,
   output logic                ld_issue_ready,
   input  logic                ld_resp_valid,
   input  logic [REG_LEN-1:0]  ld_resp_d,
   input  logic [ADDR_LEN-1:0] chk_rs1,
   input  logic [ADDR_LEN-1:0] chk_rs2,
   input  logic [ADDR_LEN-1:0] chk_rd,
   output logic                stall,
   output logic                reg_wr,
   output logic [ADDR_LEN-1:0] rd,
   output logic [REG_LEN-1:0]  rd_d,
   output logic                err
);

   logic                                   fifo_full;
   logic                                   fifo_empty;
   logic [ADDR_LEN-1:0]                    head_rd;
   logic [WB_NUM_CHK-1:0]                  fifo_hit;
   logic [WB_NUM_CHK-1:0][ADDR_LEN-1:0]    chk;

   logic                skid_valid;
   logic [ADDR_LEN-1:0] skid_rd;
   logic [REG_LEN-1:0]  skid_d;

   logic                resp_ok;
   logic                push;
   logic                alu_take;
   wb_src_e             src;
   logic [ADDR_LEN-1:0] nxt_rd;
   logic [REG_LEN-1:0]  nxt_d;

   assign chk = {chk_rd, chk_rs2, chk_rs1};

   // A response only counts when a tag is waiting for it; a stray one is
   // flagged as an error and leaves the write port free.
   assign resp_ok = ld_resp_valid && !fifo_empty;

   // ld_issue_ready shows the pre-pop occupancy, but an issue that coincides
   // with a response still fits because the pop frees a slot at the edge.
   assign ld_issue_ready = !fifo_full;
   assign push           = ld_issue && (!fifo_full || resp_ok);

   assign alu_ready = !skid_valid;
   assign alu_take  = alu_valid && !skid_valid;

   wb_tag_fifo #(
      .ADDR_LEN (ADDR_LEN),
      .LD_DEPTH (LD_DEPTH),
      .NUM_CHK  (WB_NUM_CHK)
   ) u_tag_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .push_rd (ld_issue_rd),
      .pop     (resp_ok),
      .head_rd (head_rd),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .chk     (chk),
      .hit     (fifo_hit)
   );

   // Pick this cycle's owner of the write port: load response first because
   // memory cannot be held off, then the parked skid entry, then a fresh
   // ALU result.
   always_comb begin
      src    = SRC_NONE;
      nxt_rd = head_rd;
      nxt_d  = ld_resp_d;
      if (resp_ok) begin
         src = SRC_LOAD;
      end else if (skid_valid) begin
         src    = SRC_SKID;
         nxt_rd = skid_rd;
         nxt_d  = skid_d;
      end else if (alu_take) begin
         src    = SRC_ALU;
         nxt_rd = alu_rd;
         nxt_d  = alu_d;
      end
   end

   // Registered write port plus skid bookkeeping. Writes to x0 still consume
   // their producer but never assert reg_wr.
   always_ff @(posedge clk) begin
      if (rst) begin
         reg_wr     <= 1'b0;
         rd         <= '0;
         rd_d       <= '0;
         err        <= 1'b0;
         skid_valid <= 1'b0;
      end else begin
         if (ld_resp_valid && fifo_empty) begin
            err <= 1'b1;
         end
         reg_wr <= (src != SRC_NONE) && (nxt_rd != '0);
         if (src != SRC_NONE) begin
            rd   <= nxt_rd;
            rd_d <= nxt_d;
         end
         if (resp_ok && alu_take) begin
            skid_valid <= 1'b1;
            skid_rd    <= alu_rd;
            skid_d     <= alu_d;
         end else if (src == SRC_SKID) begin
            skid_valid <= 1'b0;
         end
      end
   end

   // A nonzero operand is hazardous while its register is still owed a
   // write: queued in the tag FIFO, parked in skid, or being committed now.
   always_comb begin
      stall = 1'b0;
      for (int i = 0; i < WB_NUM_CHK; i++) begin
         if ((chk[i] != '0) &&
             (fifo_hit[i] || (skid_valid && (chk[i] == skid_rd)) ||
              (reg_wr && (chk[i] == rd)))) begin
            stall = 1'b1;
         end
      end
   end

endmodule
